inst_decoder: RTL and testbench

INST_DECODER -- requirements
Module: inst_decoder

---
 rtl/inst_decoder_if.sv | 34 +++
 rtl/inst_decoder.sv | 125 ++++++++++++
 tb/tb_inst_decoder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/inst_decoder_if.sv
// Handshake and decoded-control bundle between the instruction source,
// the decoder and the datapath.
interface inst_decoder_if #(
  parameter int OPCODE_W  = 5,
  parameter int OPERAND_W = 11
);
  logic                 in_valid;
  logic [15:0]          in_instr;
  logic                 in_ready;
  logic                 out_ready;
  logic                 out_valid;
  logic [OPCODE_W-1:0]  out_opcode;
  logic [OPERAND_W-1:0] out_operand;
  logic [1:0]           out_sel_a;
  logic                 out_sel_b;
  logic                 out_alu_sub;
  logic                 out_wr_acc;
  logic                 out_wr_ram;
  logic                 out_illegal;

  // Instruction source / datapath side
  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_opcode, out_operand, out_sel_a,
           out_sel_b, out_alu_sub, out_wr_acc, out_wr_ram, out_illegal
  );

  // Decoder side
  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_opcode, out_operand, out_sel_a,
           out_sel_b, out_alu_sub, out_wr_acc, out_wr_ram, out_illegal
  );
endinterface

// File: rtl/inst_decoder.sv
// Single-stage instruction decoder: registers one instruction word per
// transfer, turns its opcode into datapath control strobes, and stops
// accepting words once an HLT has been taken.
module inst_decoder #(
  parameter int OPCODE_W  = 5,
  parameter int OPERAND_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  inst_decoder_if.slave     bus,
  output logic              halted,
  output logic [15:0]       inst_count
);

  typedef enum logic {RUN, HALTED} state_t;

  localparam logic [OPCODE_W-1:0] OP_HLT  = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_STO  = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_LDI  = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_SUBI = OPCODE_W'(7);

  state_t               state, state_next;
  logic                 transfer;
  logic [OPCODE_W-1:0]  in_opcode;
  logic [OPERAND_W-1:0] in_operand;

  logic [1:0]           dec_sel_a;
  logic                 dec_sel_b, dec_alu_sub, dec_wr_acc, dec_wr_ram, dec_illegal;

  logic                 valid_q;
  logic [OPCODE_W-1:0]  opcode_q;
  logic [OPERAND_W-1:0] operand_q;
  logic [1:0]           sel_a_q;
  logic                 sel_b_q, alu_sub_q, wr_acc_q, wr_ram_q, illegal_q;

  assign in_opcode  = bus.in_instr[15 -: OPCODE_W];
  assign in_operand = bus.in_instr[OPERAND_W-1:0];

  // A word may enter only while running and the output slot is empty or draining
  assign bus.in_ready = (!valid_q || bus.out_ready) && (state == RUN);
  assign transfer     = bus.in_valid && bus.in_ready;

  // Translate the incoming opcode into control strobes; unknown opcodes give all-zero controls
  always_comb begin
    dec_sel_a   = 2'b00;
    dec_sel_b   = 1'b0;
    dec_alu_sub = 1'b0;
    dec_wr_acc  = 1'b0;
    dec_wr_ram  = 1'b0;
    dec_illegal = 1'b0;
    case (in_opcode)
      OP_HLT:  dec_illegal = 1'b0;
      OP_STO:  dec_wr_ram  = 1'b1;
      OP_LD:   dec_wr_acc  = 1'b1;
      OP_LDI:  begin dec_sel_a = 2'b01; dec_wr_acc = 1'b1; end
      OP_ADD:  begin dec_sel_a = 2'b10; dec_wr_acc = 1'b1; end
      OP_ADDI: begin dec_sel_a = 2'b10; dec_sel_b = 1'b1; dec_wr_acc = 1'b1; end
      OP_SUB:  begin dec_sel_a = 2'b10; dec_alu_sub = 1'b1; dec_wr_acc = 1'b1; end
      OP_SUBI: begin dec_sel_a = 2'b10; dec_sel_b = 1'b1; dec_alu_sub = 1'b1; dec_wr_acc = 1'b1; end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Taking an HLT word is the only way into HALTED, and only reset leaves it
  always_comb begin
    state_next = state;
    if (state == RUN && transfer && in_opcode == OP_HLT)
      state_next = HALTED;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  // Output slot: load on transfer, empty on drain, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      opcode_q  <= '0;
      operand_q <= '0;
      sel_a_q   <= 2'b00;
      sel_b_q   <= 1'b0;
      alu_sub_q <= 1'b0;
      wr_acc_q  <= 1'b0;
      wr_ram_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else if (transfer) begin
      valid_q   <= 1'b1;
      opcode_q  <= in_opcode;
      operand_q <= in_operand;
      sel_a_q   <= dec_sel_a;
      sel_b_q   <= dec_sel_b;
      alu_sub_q <= dec_alu_sub;
      wr_acc_q  <= dec_wr_acc;
      wr_ram_q  <= dec_wr_ram;
      illegal_q <= dec_illegal;
    end else if (valid_q && bus.out_ready) begin
      valid_q   <= 1'b0;
    end
  end

  // Saturating count of accepted words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              inst_count <= 16'h0000;
    else if (transfer && inst_count != 16'hFFFF) inst_count <= inst_count + 16'd1;
  end

  assign halted          = (state == HALTED);
  assign bus.out_valid   = valid_q;
  assign bus.out_opcode  = opcode_q;
  assign bus.out_operand = operand_q;
  assign bus.out_sel_a   = sel_a_q;
  assign bus.out_sel_b   = sel_b_q;
  assign bus.out_alu_sub = alu_sub_q;
  assign bus.out_wr_acc  = wr_acc_q;
  assign bus.out_wr_ram  = wr_ram_q;
  assign bus.out_illegal = illegal_q;

endmodule

// File: tb/tb_inst_decoder.sv
// Self-checking bench for inst_decoder: directed scenarios with literal
// expectations, then randomized traffic against a word-level reference model.
module tb_inst_decoder;

  logic        clk;
  logic        rst_n;
  logic        halted;
  logic [15:0] inst_count;

  inst_decoder_if #(.OPCODE_W(5), .OPERAND_W(11)) bus ();

  inst_decoder #(.OPCODE_W(5), .OPERAND_W(11)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .halted     (halted),
    .inst_count (inst_count)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: the word sitting in the output slot
  logic        m_valid;
  logic [15:0] m_word;
  logic        m_halted;
  logic [15:0] m_count;

  // Controls per opcode 0..7 as {sel_a, sel_b, alu_sub, wr_acc, wr_ram}
  logic [5:0] ctrl_tab [8];

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [10:0] operand);
    return {op, operand};
  endfunction

  // Expected {illegal, sel_a, sel_b, alu_sub, wr_acc, wr_ram} for a word
  function automatic logic [6:0] expCtrl(input logic [15:0] word);
    if (word[15:11] > 5'd7) return 7'b1000000;
    return {1'b0, ctrl_tab[word[13:11]]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] instr, input logic ordy);
    bus.in_valid  = v;
    bus.in_instr  = instr;
    bus.out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // Reference model: word-level view of the slot, the halt flag and the counter
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid  = 1'b0;
      m_word   = 16'h0000;
      m_halted = 1'b0;
      m_count  = 16'h0000;
    end else begin
      if (bus.in_valid && (!m_valid || bus.out_ready) && !m_halted) begin
        m_valid = 1'b1;
        m_word  = bus.in_instr;
        if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
        if (bus.in_instr[15:11] == 5'd0) m_halted = 1'b1;
      end else if (m_valid && bus.out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    logic [6:0] e;
    e = expCtrl(m_word);
    checkOutput("mon_out_valid", 32'(bus.out_valid), 32'(m_valid));
    checkOutput("mon_in_ready", 32'(bus.in_ready), 32'((!m_valid || bus.out_ready) && !m_halted));
    checkOutput("mon_halted", 32'(halted), 32'(m_halted));
    checkOutput("mon_inst_count", 32'(inst_count), 32'(m_count));
    if (m_valid) begin
      checkOutput("mon_opcode", 32'(bus.out_opcode), 32'(m_word[15:11]));
      checkOutput("mon_operand", 32'(bus.out_operand), 32'(m_word[10:0]));
      checkOutput("mon_ctrl", 32'({bus.out_illegal, bus.out_sel_a, bus.out_sel_b,
                                   bus.out_alu_sub, bus.out_wr_acc, bus.out_wr_ram}), 32'(e));
    end
  end

  // Directed scenarios followed by randomized traffic
  initial begin
    ctrl_tab[0] = 6'b00_0_0_0_0;  // HLT
    ctrl_tab[1] = 6'b00_0_0_0_1;  // STO
    ctrl_tab[2] = 6'b00_0_0_1_0;  // LD
    ctrl_tab[3] = 6'b01_0_0_1_0;  // LDI
    ctrl_tab[4] = 6'b10_0_0_1_0;  // ADD
    ctrl_tab[5] = 6'b10_1_0_1_0;  // ADDI
    ctrl_tab[6] = 6'b10_0_1_1_0;  // SUB
    ctrl_tab[7] = 6'b10_1_1_1_0;  // SUBI

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = 16'h0000;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_halted", 32'(halted), 32'd0);
    checkOutput("rst_inst_count", 32'(inst_count), 32'd0);
    checkOutput("rst_opcode", 32'(bus.out_opcode), 32'd0);
    rst_n = 1'b1;

    // LDI with a negative immediate
    applyStimulus(1'b1, 16'h1D8E, 1'b1);
    checkOutput("ldi_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("ldi_opcode", 32'(bus.out_opcode), 32'h03);
    checkOutput("ldi_operand", 32'(bus.out_operand), 32'h58E);
    checkOutput("ldi_sel_a", 32'(bus.out_sel_a), 32'h1);
    checkOutput("ldi_wr_acc", 32'(bus.out_wr_acc), 32'd1);
    checkOutput("ldi_count", 32'(inst_count), 32'd1);

    // Back-to-back ADD, SUBI, STO from a fresh reset
    pulseReset();
    applyStimulus(1'b1, mk(5'd4, 11'h001), 1'b1);
    checkOutput("add_ctrl", 32'({bus.out_sel_a, bus.out_sel_b, bus.out_alu_sub, bus.out_wr_acc, bus.out_wr_ram}), 32'b10_0_0_1_0);
    applyStimulus(1'b1, mk(5'd7, 11'h7FF), 1'b1);
    checkOutput("subi_ctrl", 32'({bus.out_sel_a, bus.out_sel_b, bus.out_alu_sub, bus.out_wr_acc, bus.out_wr_ram}), 32'b10_1_1_1_0);
    applyStimulus(1'b1, mk(5'd1, 11'h020), 1'b1);
    checkOutput("sto_ctrl", 32'({bus.out_sel_a, bus.out_sel_b, bus.out_alu_sub, bus.out_wr_acc, bus.out_wr_ram}), 32'b00_0_0_0_1);
    checkOutput("stream_count", 32'(inst_count), 32'd3);

    // SUB held under back-pressure, then released
    applyStimulus(1'b1, mk(5'd6, 11'h155), 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, mk(5'd5, 11'h0AA), 1'b0);
      checkOutput("stall_opcode", 32'(bus.out_opcode), 32'h06);
      checkOutput("stall_operand", 32'(bus.out_operand), 32'h155);
      checkOutput("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    checkOutput("unstall_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("unstall_opcode", 32'(bus.out_opcode), 32'h05);
    checkOutput("unstall_count", 32'(inst_count), 32'd5);

    // Highest undefined opcode
    applyStimulus(1'b1, 16'hF800, 1'b1);
    checkOutput("ill_flag", 32'(bus.out_illegal), 32'd1);
    checkOutput("ill_ctrl", 32'({bus.out_sel_a, bus.out_sel_b, bus.out_alu_sub, bus.out_wr_acc, bus.out_wr_ram}), 32'd0);
    checkOutput("ill_halted", 32'(halted), 32'd0);

    // Reset in the middle of a stall throws the held word away
    applyStimulus(1'b1, mk(5'd2, 11'h3C3), 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst_opcode", 32'(bus.out_opcode), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd1);

    // HLT drains once, then nothing else gets in
    applyStimulus(1'b1, mk(5'd0, 11'h123), 1'b1);
    checkOutput("hlt_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("hlt_halted", 32'(halted), 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, mk(5'd4, 11'h00F), 1'b1);
      checkOutput("post_hlt_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("post_hlt_in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("post_hlt_count", 32'(inst_count), 32'd1);
    end
    pulseReset();
    checkOutput("unhalt_halted", 32'(halted), 32'd0);
    checkOutput("unhalt_count", 32'(inst_count), 32'd0);

    // Randomized traffic, with occasional resets to escape HALTED
    for (int i = 0; i < 4000; i++) begin
      int r;
      logic [4:0] op;
      if (m_halted && $urandom_range(0, 9) == 0) pulseReset();
      r = int'($urandom_range(0, 99));
      if (r < 2)       op = 5'd0;
      else if (r < 14) op = 5'($urandom_range(8, 31));
      else             op = 5'($urandom_range(1, 7));
      applyStimulus($urandom_range(0, 3) != 0, mk(op, 11'($urandom_range(0, 2047))),
                    $urandom_range(0, 3) != 0);
    end

    applyStimulus(1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
